// File: rtl/serializer_if.sv
// Parallel-side handshake bundle for the serial command link transmitter.
// The source drives word, command bit and valid; the serializer returns ready.
interface serializer_if #(
  parameter int DATA_W = 5
);
  logic [DATA_W-1:0] data_i;
  logic              command_i;
  logic              valid_i;
  logic              ready_o;

  modport master (
    output data_i,
    output command_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  data_i,
    input  command_i,
    input  valid_i,
    output ready_o
  );
endinterface

// File: rtl/serializer.sv
// Serial command link transmitter: DATA_W data bits MSB first, then command bit.
// Optional macro SERIALIZER_SKID_BUF_EN adds a one-entry holding register.
module serializer #(
  parameter int DATA_W   = 5,
  parameter int IDLE_GAP = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  serializer_if.slave in_if,
  output logic        ser_data_o,
  output logic        data_val_o,
  output logic        busy_o
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CMD,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_nx;
  logic              cmd_q, cmd_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              ser_q, ser_d;
  logic              val_q, val_d;
  logic              busy_q, busy_d;
  logic              ready, accept;
  logic              frame_end;
  logic              ld;
  logic [DATA_W-1:0] ld_data;
  logic              ld_cmd;

`ifdef SERIALIZER_SKID_BUF_EN
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hcmd_q, hcmd_d;
  logic              hfull_q, hfull_d;

  assign ready = rst_ni & ~hfull_q;
`else
  assign ready = rst_ni & (state_q == S_IDLE);
`endif

  assign accept        = in_if.valid_i & ready;
  assign in_if.ready_o = ready;
  assign ser_data_o    = ser_q;
  assign data_val_o    = val_q;
  assign busy_o        = busy_q;

  // Next state, shifter/counter updates and next registered outputs
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cmd_d     = cmd_q;
    bcnt_d    = bcnt_q;
    gcnt_d    = gcnt_q;
    ser_d     = 1'b0;
    val_d     = 1'b0;
    busy_d    = 1'b0;
    frame_end = 1'b0;
    ld        = 1'b0;
    ld_data   = in_if.data_i;
    ld_cmd    = in_if.command_i;
    sh_nx     = sh_q << 1;
`ifdef SERIALIZER_SKID_BUF_EN
    hold_d    = hold_q;
    hcmd_d    = hcmd_q;
    hfull_d   = hfull_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        ld = accept;
      end
      S_DATA: begin
        busy_d = 1'b1;
        if (bcnt_q == BW'(1)) begin
          state_d = S_CMD;
          ser_d   = cmd_q;
        end else begin
          sh_d   = sh_nx;
          bcnt_d = bcnt_q - BW'(1);
          ser_d  = sh_nx[DATA_W-1];
        end
      end
      S_CMD: begin
        if (IDLE_GAP > 0) begin
          state_d = S_GAP;
          gcnt_d  = GW'(IDLE_GAP);
          busy_d  = 1'b1;
        end else begin
          frame_end = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt_q == GW'(1)) begin
          frame_end = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_end) begin
      state_d = S_IDLE;
    end

`ifdef SERIALIZER_SKID_BUF_EN
    // Held word wins the shifter; an empty holder lets a new word bypass it
    if (frame_end && hfull_q) begin
      ld      = 1'b1;
      ld_data = hold_q;
      ld_cmd  = hcmd_q;
      hfull_d = 1'b0;
    end else if (frame_end) begin
      ld = accept;
    end
    if (accept && (state_q != S_IDLE) && !(frame_end && !hfull_q)) begin
      hold_d  = in_if.data_i;
      hcmd_d  = in_if.command_i;
      hfull_d = 1'b1;
    end
`endif

    if (ld) begin
      state_d = S_DATA;
      sh_d    = ld_data;
      cmd_d   = ld_cmd;
      bcnt_d  = BW'(DATA_W);
      ser_d   = ld_data[DATA_W-1];
      val_d   = 1'b1;
      busy_d  = 1'b1;
    end
  end

  // State, datapath and registered outputs; reset aborts any frame
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cmd_q   <= 1'b0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      ser_q   <= 1'b0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cmd_q   <= cmd_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      ser_q   <= ser_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SERIALIZER_SKID_BUF_EN
  // Holding register for a word accepted while a frame is in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q  <= '0;
      hcmd_q  <= 1'b0;
      hfull_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      hcmd_q  <= hcmd_d;
      hfull_q <= hfull_d;
    end
  end
`endif

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: reset, frame vectors, back-to-back, gap, abort, random.
// Expectations follow SERIALIZER_SKID_BUF_EN when it is defined.
`timescale 1ns/1ps
module tb_serializer;
  localparam int W = 5;
`ifdef SERIALIZER_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serializer_if #(.DATA_W(W)) if0 ();
  serializer_if #(.DATA_W(W)) if1 ();
  logic ser0, val0, busy0;
  logic ser1, val1, busy1;

  serializer #(.DATA_W(W), .IDLE_GAP(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .in_if(if0.slave),
    .ser_data_o(ser0), .data_val_o(val0), .busy_o(busy0)
  );

  serializer #(.DATA_W(W), .IDLE_GAP(2)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_if(if1.slave),
    .ser_data_o(ser1), .data_val_o(val1), .busy_o(busy1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] d;
    logic         c;
    logic [5:0]   exp_s;
  } vec_t;
  vec_t tbl [5];

  typedef struct packed {
    logic s;
    logic v;
    logic b;
  } ob_t;
  ob_t mq [$];

  task automatic push_frame(input logic [W-1:0] d, input logic c);
    for (int i = W - 1; i >= 0; i--) begin
      mq.push_back('{d[i], (i == W - 1), 1'b1});
    end
    mq.push_back('{c, 1'b0, 1'b1});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if0.valid_i = 1'b0;
    if1.valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input logic [W-1:0] d, input logic c,
                           output logic [5:0] s, output logic [5:0] v,
                           output logic [5:0] b);
    int n = 0;
    while (!if0.ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(if0.ready_o), 1);
    if0.data_i = d;
    if0.command_i = c;
    if0.valid_i = 1'b1;
    @(negedge clk);
    if0.valid_i = 1'b0;
    if0.data_i = ~d;
    if0.command_i = ~c;
    for (int i = 0; i < 6; i++) begin
      s[5-i] = ser0;
      v[5-i] = val0;
      b[5-i] = busy0;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] s, v, b;
    int t1, t2, gl, zb, idle_b, cnt;
    logic vv, cc, pr, acc, hfull, hc;
    logic [W-1:0] dd, hd;
    ob_t cur;

    tbl[0] = '{5'b10110, 1'b1, 6'b101101};
    tbl[1] = '{5'h1F, 1'b0, 6'b111110};
    tbl[2] = '{5'h00, 1'b1, 6'b000001};
    tbl[3] = '{5'h15, 1'b1, 6'b101011};
    tbl[4] = '{5'h0A, 1'b0, 6'b010100};

    if0.valid_i = 1'b0; if0.data_i = '0; if0.command_i = 1'b0;
    if1.valid_i = 1'b0; if1.data_i = '0; if1.command_i = 1'b0;

    // reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ser", ser0, 0);
    chk("rst_val", val0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", if0.ready_o, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", if0.ready_o, 1);
    chk("rel_busy", busy0, 0);
    @(negedge clk);

    // table-driven frames with loopback decode
    for (int k = 0; k < 5; k++) begin
      run_frame(tbl[k].d, tbl[k].c, s, v, b);
      chk($sformatf("ser_seq%0d", k), s, tbl[k].exp_s);
      chk($sformatf("val_seq%0d", k), v, 6'b100000);
      chk($sformatf("busy_seq%0d", k), b, 6'b111111);
      chk($sformatf("loop_data%0d", k), s[5:1], tbl[k].d);
      chk($sformatf("loop_cmd%0d", k), s[0], tbl[k].c);
      chk($sformatf("idle_after%0d", k), busy0, 0);
    end

    // valid held across two frames
    do_reset();
    if0.valid_i = 1'b1; if0.data_i = 5'h13; if0.command_i = 1'b1;
    t1 = -1; t2 = -1; idle_b = 0;
    for (int cyc = 0; cyc < 40 && t2 < 0; cyc++) begin
      @(negedge clk);
      if (val0) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end else if (t1 >= 0 && !busy0) begin
        idle_b++;
      end
    end
    if0.valid_i = 1'b0;
    chk("b2b_found", int'(t2 >= 0), 1);
    chk("b2b_period", t2 - t1, SKID ? 6 : 7);
    chk("b2b_idle", idle_b, SKID ? 0 : 1);

    // IDLE_GAP=2 with two queued frames
    do_reset();
    if1.valid_i = 1'b1; if1.data_i = 5'h0B; if1.command_i = 1'b1;
    t1 = -1; t2 = -1; gl = 0; zb = 0;
    for (int cyc = 0; cyc < 60 && t2 < 0; cyc++) begin
      @(negedge clk);
      if (val1) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end else if (t1 >= 0 && cyc > t1 + 5) begin
        gl++;
        if (!ser1 && busy1) zb++;
      end
    end
    if1.valid_i = 1'b0;
    chk("gap_found", int'(t2 >= 0), 1);
    chk("gap_zero_busy", zb, 2);
    chk("gap_len", gl, SKID ? 2 : 3);

    // reset during the third data bit
    do_reset();
    if0.data_i = 5'h1F; if0.command_i = 1'b1; if0.valid_i = 1'b1;
    @(negedge clk);
    if0.valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_bit3", ser0, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ser", ser0, 0);
    chk("abort_val", val0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_ready", if0.ready_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ser0 || busy0) cnt++;
    end
    chk("abort_no_cmd", cnt, 0);
    run_frame(5'h11, 1'b1, s, v, b);
    chk("post_abort_ser", s, 6'b100011);
    chk("post_abort_val", v, 6'b100000);
    chk("post_abort_busy", b, 6'b111111);

    // random traffic against the queue model
    do_reset();
    mq.delete();
    cur = '0; hfull = 1'b0; hd = '0; hc = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      vv = ($urandom_range(0, 2) != 0);
      dd = W'($urandom);
      cc = 1'($urandom);
      if0.valid_i = vv; if0.data_i = dd; if0.command_i = cc;
      pr = SKID ? !hfull : !cur.b;
      #1;
      chk("rnd_ready", if0.ready_o, pr);
      acc = vv && pr;
      @(posedge clk);
      if (SKID && mq.size() == 0 && hfull) begin
        push_frame(hd, hc);
        hfull = 1'b0;
      end
      if (acc) begin
        if (mq.size() == 0) begin
          push_frame(dd, cc);
        end else begin
          hd = dd; hc = cc; hfull = 1'b1;
        end
      end
      cur = (mq.size() > 0) ? mq.pop_front() : '0;
      #1;
      chk("rnd_ser", ser0, cur.s);
      chk("rnd_val", val0, cur.v);
      chk("rnd_busy", busy0, cur.b);
      @(negedge clk);
    end
    if0.valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
